// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, stall hold, run/halt FSM and a
// circular return-address stack feeding the instruction-memory address.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_done            halt request (sticky until reset)
//   i_stall           hold PC this cycle
//   i_br_taken        branch taken, destination i_br_target
//   i_jump            unconditional jump to i_jump_target
//   i_call            jump to i_jump_target and push pc+INC
//   i_ret             pop RAS top into PC (i_ret_target when RAS empty)
//   o_pc              current instruction address
//   o_pc_valid        running and not stalled
//   o_halted          in HALT state
//   o_ras_empty       RAS holds no entries
//   o_ras_full        RAS holds RAS_DEPTH entries
//   o_misalign        sticky: a loaded target had nonzero bits [1:0]
module pc_unit #(
    parameter int unsigned XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned INC       = 4,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_done,
    input  logic            i_stall,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_target,
    input  logic            i_jump,
    input  logic            i_call,
    input  logic [XLEN-1:0] i_jump_target,
    input  logic            i_ret,
    input  logic [XLEN-1:0] i_ret_target,
    output logic [XLEN-1:0] o_pc,
    output logic            o_pc_valid,
    output logic            o_halted,
    output logic            o_ras_empty,
    output logic            o_ras_full,
    output logic            o_misalign
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(RAS_DEPTH);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_adv;

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;

    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_top;
    logic [PW-1:0]   w_ptr_dec;
    logic [XLEN-1:0] w_raw;
    logic            w_load;
    logic            w_push;
    logic            w_pop;
    logic            w_ras_nonempty;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: HALT is only left through reset
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN:   if (i_done) w_state_nxt = S_HALT;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_halted   = (r_state == S_HALT);
        o_pc_valid = (r_state == S_RUN) && !i_stall && !rst;
        w_adv      = (r_state == S_RUN) && !i_done && !i_stall;
    end

    // Target selection; ret outranks call so a simultaneous call never pushes
    always_comb begin
        w_pc_inc       = r_pc + XLEN'(INC);
        w_ptr_dec      = r_ptr - PW'(1);
        w_top          = r_ras[w_ptr_dec];
        w_ras_nonempty = (r_cnt != '0);
        w_raw          = '0;
        w_load         = 1'b0;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        if (w_adv) begin
            if (i_ret) begin
                w_load = 1'b1;
                w_pop  = w_ras_nonempty;
                w_raw  = w_ras_nonempty ? w_top : i_ret_target;
            end else if (i_call) begin
                w_load = 1'b1;
                w_push = 1'b1;
                w_raw  = i_jump_target;
            end else if (i_jump) begin
                w_load = 1'b1;
                w_raw  = i_jump_target;
            end else if (i_br_taken) begin
                w_load = 1'b1;
                w_raw  = i_br_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
        end else if (w_adv) begin
            if (w_load) begin
                r_pc <= {w_raw[XLEN-1:2], 2'b00};
                if (w_raw[1:0] != 2'b00) r_misalign <= 1'b1;
            end else begin
                r_pc <= w_pc_inc;
            end
        end
    end

    // Pointer addresses the next free slot; a push when full overwrites
    // the oldest entry because the pointer simply wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_ptr <= r_ptr + PW'(1);
            if (r_cnt != C_FULL) r_cnt <= r_cnt + CW'(1);
        end else if (w_pop) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_ras[r_ptr] <= w_pc_inc;
    end

    assign o_pc        = r_pc;
    assign o_misalign  = r_misalign;
    assign o_ras_empty = (r_cnt == '0);
    assign o_ras_full  = (r_cnt == C_FULL);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based reference model predicts
// every post-edge output bundle; a monitor pops and compares.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done = 0, stall = 0, br = 0, jump = 0, call = 0, ret = 0;
    logic [31:0] br_t = '0, jmp_t = '0, ret_t = '0;
    logic [31:0] pc;
    logic        pc_valid, halted, ras_empty, ras_full, misalign;

    pc_unit #(
        .XLEN(32), .RESET_VEC(32'h0), .INC(4), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_done(done), .i_stall(stall),
        .i_br_taken(br), .i_br_target(br_t),
        .i_jump(jump), .i_call(call), .i_jump_target(jmp_t),
        .i_ret(ret), .i_ret_target(ret_t),
        .o_pc(pc), .o_pc_valid(pc_valid), .o_halted(halted),
        .o_ras_empty(ras_empty), .o_ras_full(ras_full),
        .o_misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        v, h, e, f, m;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] m_pc;
    bit          m_halt, m_mis;
    logic [31:0] m_ras[$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // Monitor: compare each predicted bundle just after its edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_valid", {31'b0, pc_valid}, {31'b0, e.v});
            chk("halted", {31'b0, halted}, {31'b0, e.h});
            chk("ras_empty", {31'b0, ras_empty}, {31'b0, e.e});
            chk("ras_full", {31'b0, ras_full}, {31'b0, e.f});
            chk("misalign", {31'b0, misalign}, {31'b0, e.m});
        end
    end

    function automatic void model_reset();
        m_pc   = 32'h0;
        m_halt = 0;
        m_mis  = 0;
        m_ras.delete();
    endfunction

    // Behavioural rules: priority chain, RAS as a bounded LIFO that
    // discards its oldest entry on overflow.
    function automatic void model_step();
        logic [31:0] raw;
        bit          ld;
        raw = '0;
        ld  = 0;
        if (m_halt) return;
        if (done) begin
            m_halt = 1;
            return;
        end
        if (stall) return;
        if (ret) begin
            ld = 1;
            if (m_ras.size() > 0) raw = m_ras.pop_back();
            else raw = ret_t;
        end else if (call) begin
            ld = 1;
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
            raw = jmp_t;
        end else if (jump) begin
            ld  = 1;
            raw = jmp_t;
        end else if (br) begin
            ld  = 1;
            raw = br_t;
        end
        if (ld) begin
            if (raw % 4 != 0) m_mis = 1;
            m_pc = raw - (raw % 4);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endfunction

    // Entered and left at a falling edge
    task automatic step(input logic d, s, b, input logic [31:0] bt,
                        input logic j, c, input logic [31:0] jt,
                        input logic r, input logic [31:0] rt);
        exp_t e;
        done = d; stall = s; br = b; br_t = bt;
        jump = j; call = c; jmp_t = jt; ret = r; ret_t = rt;
        @(posedge clk);
        model_step();
        e.pc = m_pc;
        e.h  = m_halt;
        e.v  = !m_halt && !s;
        e.e  = (m_ras.size() == 0);
        e.f  = (m_ras.size() == 4);
        e.m  = m_mis;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        done = 0; stall = 0; br = 0; jump = 0; call = 0; ret = 0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("rst_full", {31'b0, ras_full}, 32'h0);
        chk("rst_mis", {31'b0, misalign}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [31:0] rtgt();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // sequential fetch then stall and jump-over-branch priority
        idle(4);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h40, 1, 0, 32'h80, 0, 0);

        // RAS overflow: five calls, five returns
        do_reset();
        for (int i = 1; i <= 5; i++)
            step(0, 0, 0, 0, 0, 1, 32'(i * 32'h100), 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
        // call and ret together: ret wins, no push
        step(0, 0, 0, 0, 0, 1, 32'h800, 1, 32'h2000);

        // halt holds despite jump, with a full RAS
        do_reset();
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 1, 32'h20, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 0, 1, 0, 32'h300, 0, 0);
        do_reset();
        idle(1);

        // misaligned target and PC wrap
        step(0, 0, 0, 0, 1, 0, 32'h103, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0);
        idle(2);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 79) == 0,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) == 0, rtgt(),
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) == 0, rtgt(),
                     $urandom_range(0, 3) == 0, rtgt());
            end
        end

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
